// File: rtl/int_out_ctrl.sv
// int_out_ctrl: line sequencer for the interpolator output stage (issue, pipeline tracking, output handshake).
// Define INT_OUT_STALL_CNT_EN to build the saturating backpressure stall counter behind STALL_CNT.
module int_out_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int PIPE_LAT  = 2
) (
    input  logic        CLK,
    input  logic        RST_ASYNC,
    input  logic        START,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic        PIPE_EN,
    output logic        OUT_WRITE_EN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  LINE_IDX,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] STALL_CNT
);

    // state    | meaning
    // ST_IDLE  | waiting for START, counters hold their last block values
    // ST_RUN   | accepting lines until NUM_LINES have been issued
    // ST_FLUSH | all lines issued, draining pipeline and output register
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] LINES_CNT = 8'(NUM_LINES);
    localparam logic [7:0] LAST_IDX  = 8'(NUM_LINES - 1);

    state_t              state_q, state_d;
    logic [7:0]          issue_cnt_q, issue_cnt_d;
    logic [7:0]          retire_cnt_q, retire_cnt_d;
    logic [7:0]          line_idx_q, line_idx_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;

    logic busy;
    logic adv;
    logic in_ready;
    logic accept;
    logic write_en;
    logic consume;
    logic last_consume;
    logic start_blk;

    always_comb begin
        busy         = (state_q != ST_IDLE);
        adv          = !(out_valid_q && !OUT_READY);
        in_ready     = (state_q == ST_RUN) && adv && (issue_cnt_q < LINES_CNT);
        accept       = IN_VALID && in_ready;
        write_en     = adv && vld_q[PIPE_LAT-1];
        consume      = out_valid_q && OUT_READY;
        last_consume = consume && (retire_cnt_q == LAST_IDX);
        // DONE is high for the first IDLE cycle; a START landing on it must not relaunch
        start_blk    = (state_q == ST_IDLE) && START && !done_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_blk) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (issue_cnt_q == LAST_IDX)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (last_consume) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        retire_cnt_d = retire_cnt_q;
        line_idx_d   = line_idx_q;
        vld_d        = vld_q;
        out_valid_d  = out_valid_q;
        done_d       = last_consume;

        if (start_blk) begin
            issue_cnt_d  = '0;
            retire_cnt_d = '0;
            line_idx_d   = '0;
            vld_d        = '0;
        end else begin
            if (accept) begin
                issue_cnt_d = issue_cnt_q + 8'd1;
            end
            if (consume) begin
                retire_cnt_d = retire_cnt_q + 8'd1;
                if (!last_consume) begin
                    line_idx_d = line_idx_q + 8'd1;
                end
            end
            // Valid tags move in lockstep with the filter stages, so they freeze on a stall
            if (adv && busy) begin
                for (int i = PIPE_LAT - 1; i > 0; i--) begin
                    vld_d[i] = vld_q[i-1];
                end
                vld_d[0] = accept;
            end
        end

        if (write_en) begin
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= '0;
            retire_cnt_q <= '0;
            line_idx_q   <= '0;
            vld_q        <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            line_idx_q   <= line_idx_d;
            vld_q        <= vld_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef INT_OUT_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_blk) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !OUT_READY && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`else
    assign STALL_CNT = 16'h0000;
`endif

    assign IN_READY     = in_ready;
    assign PIPE_EN      = adv && busy;
    assign OUT_WRITE_EN = write_en;
    assign OUT_VALID    = out_valid_q;
    assign LINE_IDX     = line_idx_q;
    assign BUSY         = busy;
    assign DONE         = done_q;

endmodule

// File: tb/tb_int_out_ctrl.sv
// Bench for int_out_ctrl: two configurations (8 lines/2 stages and 1 line/1 stage) against a line-level model.
module tb_int_out_ctrl;

    localparam int NL0 = 8;
    localparam int PL0 = 2;
    localparam int NL1 = 1;
    localparam int PL1 = 1;
`ifdef INT_OUT_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_i[2];
    logic        in_valid_i[2];
    logic        out_ready_i[2];
    logic        in_ready_o[2];
    logic        pipe_en_o[2];
    logic        wr_o[2];
    logic        out_valid_o[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic [7:0]  line_idx_o[2];
    logic [15:0] stall_cnt_o[2];

    int tests_run    = 0;
    int tests_failed = 0;

    int_out_ctrl #(.NUM_LINES(NL0), .PIPE_LAT(PL0)) u_dut0 (
        .CLK(clk), .RST_ASYNC(rst), .START(start_i[0]), .IN_VALID(in_valid_i[0]),
        .IN_READY(in_ready_o[0]), .PIPE_EN(pipe_en_o[0]), .OUT_WRITE_EN(wr_o[0]),
        .OUT_VALID(out_valid_o[0]), .OUT_READY(out_ready_i[0]), .LINE_IDX(line_idx_o[0]),
        .BUSY(busy_o[0]), .DONE(done_o[0]), .STALL_CNT(stall_cnt_o[0])
    );

    int_out_ctrl #(.NUM_LINES(NL1), .PIPE_LAT(PL1)) u_dut1 (
        .CLK(clk), .RST_ASYNC(rst), .START(start_i[1]), .IN_VALID(in_valid_i[1]),
        .IN_READY(in_ready_o[1]), .PIPE_EN(pipe_en_o[1]), .OUT_WRITE_EN(wr_o[1]),
        .OUT_VALID(out_valid_o[1]), .OUT_READY(out_ready_i[1]), .LINE_IDX(line_idx_o[1]),
        .BUSY(busy_o[1]), .DONE(done_o[1]), .STALL_CNT(stall_cnt_o[1])
    );

    // Line-level model: each pipeline slot and the output register hold a line number, -1 when empty
    bit m_active[2];
    int m_accepted[2];
    int m_retired[2];
    int m_out_line[2];
    int m_pipe[2][8];
    bit m_done[2];
    int m_stall[2];

    function automatic int nl(int d);
        return (d == 0) ? NL0 : NL1;
    endfunction

    function automatic int pl(int d);
        return (d == 0) ? PL0 : PL1;
    endfunction

    function automatic bit e_stall(int d);
        return (m_out_line[d] >= 0) && !out_ready_i[d];
    endfunction

    function automatic bit e_in_ready(int d);
        return m_active[d] && (m_accepted[d] < nl(d)) && !e_stall(d);
    endfunction

    function automatic bit e_wr(int d);
        return !e_stall(d) && (m_pipe[d][pl(d)-1] >= 0);
    endfunction

    function automatic int e_line_idx(int d);
        if (m_out_line[d] >= 0) return m_out_line[d];
        return (m_retired[d] < nl(d)) ? m_retired[d] : nl(d) - 1;
    endfunction

    function automatic int e_stall_cnt(int d);
        return STALL_EN ? m_stall[d] : 0;
    endfunction

    task automatic model_reset(int d);
        m_active[d]   = 1'b0;
        m_accepted[d] = 0;
        m_retired[d]  = 0;
        m_out_line[d] = -1;
        m_done[d]     = 1'b0;
        m_stall[d]    = 0;
        for (int i = 0; i < 8; i++) m_pipe[d][i] = -1;
    endtask

    task automatic model_edge(int d);
        bit stall, acc, cons;
        int tail;
        stall = e_stall(d);
        acc   = e_in_ready(d) && in_valid_i[d];
        cons  = (m_out_line[d] >= 0) && out_ready_i[d];
        tail  = m_pipe[d][pl(d)-1];
        if (stall && m_stall[d] < 65535) m_stall[d]++;
        if (!m_active[d]) begin
            if (start_i[d] && !m_done[d]) begin
                m_active[d]   = 1'b1;
                m_accepted[d] = 0;
                m_retired[d]  = 0;
                m_stall[d]    = 0;
                for (int i = 0; i < 8; i++) m_pipe[d][i] = -1;
            end
            m_done[d] = 1'b0;
        end else begin
            m_done[d] = 1'b0;
            if (cons) begin
                m_retired[d]++;
                m_out_line[d] = -1;
                if (m_retired[d] == nl(d)) begin
                    m_done[d]   = 1'b1;
                    m_active[d] = 1'b0;
                end
            end
            if (!stall) begin
                if (tail >= 0) m_out_line[d] = tail;
                for (int i = pl(d) - 1; i > 0; i--) m_pipe[d][i] = m_pipe[d][i-1];
                m_pipe[d][0] = acc ? m_accepted[d] : -1;
                if (acc) m_accepted[d]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(int d);
        chk($sformatf("u%0d.IN_READY", d),     32'(in_ready_o[d]),  32'(e_in_ready(d)));
        chk($sformatf("u%0d.PIPE_EN", d),      32'(pipe_en_o[d]),   32'(m_active[d] && !e_stall(d)));
        chk($sformatf("u%0d.OUT_WRITE_EN", d), 32'(wr_o[d]),        32'(e_wr(d)));
        chk($sformatf("u%0d.OUT_VALID", d),    32'(out_valid_o[d]), 32'(m_out_line[d] >= 0));
        chk($sformatf("u%0d.LINE_IDX", d),     32'(line_idx_o[d]),  32'(e_line_idx(d)));
        chk($sformatf("u%0d.BUSY", d),         32'(busy_o[d]),      32'(m_active[d]));
        chk($sformatf("u%0d.DONE", d),         32'(done_o[d]),      32'(m_done[d]));
        chk($sformatf("u%0d.STALL_CNT", d),    32'(stall_cnt_o[d]), 32'(e_stall_cnt(d)));
    endtask

    // Inputs are set just after a falling edge; check, then take the rising edge.
    task automatic cycle();
        #1;
        check_all(0);
        check_all(1);
        @(posedge clk);
        if (!rst) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
    endtask

    task automatic cycle_fast();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic idle_inputs(int d);
        start_i[d]     = 1'b0;
        in_valid_i[d]  = 1'b0;
        out_ready_i[d] = 1'b1;
    endtask

    task automatic drain(int d, int budget);
        int n;
        n = 0;
        start_i[d]     = 1'b0;
        in_valid_i[d]  = 1'b1;
        out_ready_i[d] = 1'b1;
        while (m_active[d] && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        chk($sformatf("u%0d drain finished", d), 32'(busy_o[d]), 32'd0);
    endtask

    int n_rdy, n_wr, n_done, n_cons;
    int first_rdy, last_rdy, first_wr, last_wr;
    int acc_q[$];

    initial begin
        model_reset(0);
        model_reset(1);
        idle_inputs(0);
        idle_inputs(1);
        #1;
        for (int d = 0; d < 2; d++) check_all(d);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Full throughput, with START raised in the DONE cycle
        start_i[0] = 1'b1; in_valid_i[0] = 1'b1; out_ready_i[0] = 1'b1;
        cycle();
        n_rdy = 0; n_wr = 0; n_done = 0; n_cons = 0;
        first_rdy = -1; last_rdy = -1; first_wr = -1; last_wr = -1;
        for (int c = 0; c < 16; c++) begin
            start_i[0] = m_done[0];
            #1;
            if (in_ready_o[0]) begin
                n_rdy++; last_rdy = c;
                if (first_rdy < 0) first_rdy = c;
            end
            if (wr_o[0]) begin
                n_wr++; last_wr = c;
                if (first_wr < 0) first_wr = c;
            end
            if (out_valid_o[0]) begin
                chk("tp line_idx step", 32'(line_idx_o[0]), 32'(n_cons));
                n_cons++;
            end
            if (done_o[0]) n_done++;
            cycle();
        end
        start_i[0] = 1'b0;
        chk("tp in_ready cycles", 32'(n_rdy), 32'd8);
        chk("tp in_ready span", 32'(last_rdy - first_rdy), 32'd7);
        chk("tp write cycles", 32'(n_wr), 32'd8);
        chk("tp write span", 32'(last_wr - first_wr), 32'd7);
        chk("tp write latency", 32'(first_wr - first_rdy), 32'(PL0));
        chk("tp done pulses", 32'(n_done), 32'd1);
        chk("tp start at done ignored", 32'(busy_o[0]), 32'd0);

        // Backpressure: five stalled cycles with line 2 in the output register
        start_i[0] = 1'b1; in_valid_i[0] = 1'b1; out_ready_i[0] = 1'b1;
        cycle();
        start_i[0] = 1'b0;
        for (int c = 0; c < 20 && m_out_line[0] != 2; c++) cycle();
        chk("bp line 2 present", 32'(line_idx_o[0]), 32'd2);
        out_ready_i[0] = 1'b0;
        repeat (5) cycle();
        drain(0, 40);
        chk("bp stall count", 32'(stall_cnt_o[0]), STALL_EN ? 32'd5 : 32'd0);

        // Upstream gaps 1,0,0: each write trails its accept by PIPE_LAT
        start_i[0] = 1'b1; out_ready_i[0] = 1'b1; in_valid_i[0] = 1'b0;
        cycle();
        start_i[0] = 1'b0;
        acc_q.delete();
        for (int c = 0; c < 40; c++) begin
            in_valid_i[0] = (c % 3 == 0);
            #1;
            if (in_ready_o[0] && in_valid_i[0]) acc_q.push_back(c);
            if (wr_o[0]) begin
                chk("gap write has accept", 32'(acc_q.size() > 0), 32'd1);
                if (acc_q.size() > 0) chk("gap latency", 32'(c - acc_q.pop_front()), 32'(PL0));
            end
            cycle();
        end
        drain(0, 40);

        // Corner config: one line, one stage, START held while busy
        start_i[1] = 1'b1; in_valid_i[1] = 1'b1; out_ready_i[1] = 1'b1;
        cycle();
        n_done = 0; first_rdy = -1; first_wr = -1;
        for (int c = 0; c < 8; c++) begin
            start_i[1] = m_active[1];
            #1;
            if (in_ready_o[1] && first_rdy < 0) first_rdy = c;
            if (wr_o[1] && first_wr < 0) first_wr = c;
            if (done_o[1]) n_done++;
            cycle();
        end
        idle_inputs(1);
        chk("corner write latency", 32'(first_wr - first_rdy), 32'(PL1));
        chk("corner done pulses", 32'(n_done), 32'd1);
        chk("corner idle after block", 32'(busy_o[1]), 32'd0);

        // Randomized traffic on both configurations
        for (int c = 0; c < 4000; c++) begin
            for (int d = 0; d < 2; d++) begin
                start_i[d]     = ($urandom_range(0, 7) == 0);
                in_valid_i[d]  = ($urandom_range(0, 3) != 0);
                out_ready_i[d] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        drain(0, 200);
        drain(1, 200);
        idle_inputs(0);
        idle_inputs(1);
        cycle();

        // Asynchronous reset with three lines accepted
        start_i[0] = 1'b1; in_valid_i[0] = 1'b1; out_ready_i[0] = 1'b1;
        cycle();
        start_i[0] = 1'b0;
        for (int c = 0; c < 10 && m_accepted[0] < 3; c++) cycle();
        #2 rst = 1'b1;
        #1;
        chk("rst IN_READY", 32'(in_ready_o[0]), 32'd0);
        chk("rst PIPE_EN", 32'(pipe_en_o[0]), 32'd0);
        chk("rst OUT_WRITE_EN", 32'(wr_o[0]), 32'd0);
        chk("rst OUT_VALID", 32'(out_valid_o[0]), 32'd0);
        chk("rst LINE_IDX", 32'(line_idx_o[0]), 32'd0);
        chk("rst BUSY", 32'(busy_o[0]), 32'd0);
        chk("rst STALL_CNT", 32'(stall_cnt_o[0]), 32'd0);
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        idle_inputs(0);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (done_o[0]) n_done++;
            cycle();
        end
        chk("rst no done", 32'(n_done), 32'd0);
        chk("rst idle", 32'(busy_o[0]), 32'd0);

`ifdef INT_OUT_STALL_CNT_EN
        // Saturation of the stall counter, then clearing by START
        start_i[0] = 1'b1; in_valid_i[0] = 1'b1; out_ready_i[0] = 1'b1;
        cycle();
        start_i[0] = 1'b0;
        for (int c = 0; c < 10 && m_out_line[0] < 0; c++) cycle();
        out_ready_i[0] = 1'b0;
        repeat (70000) cycle_fast();
        cycle();
        chk("sat stall count", 32'(stall_cnt_o[0]), 32'h0000_FFFF);
        drain(0, 40);
        chk("sat held in idle", 32'(stall_cnt_o[0]), 32'h0000_FFFF);
        start_i[0] = 1'b1;
        cycle();
        start_i[0] = 1'b0;
        chk("sat cleared by start", 32'(stall_cnt_o[0]), 32'd0);
        drain(0, 40);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
